dma_block_copy: RTL
===================

Name: dma_block_copy

Overview:
Bus-initiator block that copies a block of 16-bit words from one memory address to another over the shared memory bus. It acts as a second master alongside the p18240 CPU on the memorySystem interface: data inout, address, we_L (wr_cond_code_t) and re_L (rd_cond_code_t). It uses a simple request/grant handshake with the bus arbiter. Target memory has combinational read and synchronous write, so each word costs one read cycle plus one write cycle.

Parameters:
ADDR_W, 16, address and pointer width
DATA_W, 16, data word width
CNT_W, 16, transfer-count width

Ports:
clock  input  1  system clock, all state changes on posedge
reset_L  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; sampled in IDLE only
src_addr  input  ADDR_W  first source address, latched on start
dst_addr  input  ADDR_W  first destination address, latched on start
count  input  CNT_W  number of words to copy, latched on start
bus_req  output  1  request ownership of the memory bus
bus_gnt  input  1  arbiter grant; held high by arbiter while bus_req is high
data  inout  DATA_W  shared memory data bus
address  output  ADDR_W  bus address, valid when owning the bus
we_L  output  wr_cond_code_t  MEM_WR during write cycle, else NO_WR
re_L  output  rd_cond_code_t  MEM_RD during read cycle, else NO_RD
busy  output  1  high from the cycle after an accepted start until DONE exits
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_L=0): state=IDLE; bus_req=0; busy=0; done=0; address=0; we_L=NO_WR; re_L=NO_RD; data released (Z); internal src/dst/remaining/buffer registers cleared.
- Reset mid-transfer: abort immediately with the same values. No resume. Words already written stay written.
- States:
  - IDLE: on start=1, latch src_addr, dst_addr, count. If count==0, go to DONE. Otherwise go to REQ. start is ignored in every other state.
  - REQ: bus_req=1. Stay while bus_gnt=0. On bus_gnt=1, go to READ.
  - READ: address=src; re_L=MEM_RD; we_L=NO_WR; data=Z. At the clock edge, capture data into buffer and go to WRITE.
  - WRITE: address=dst; we_L=MEM_WR; re_L=NO_RD; data driven with buffer. At the clock edge: src+=1, dst+=1, remaining-=1. If remaining was 1, go to DONE; otherwise go to READ.
  - DONE: done=1 for exactly one cycle; bus_req=0; then go to IDLE.
- Bus ownership: bus_req is high in REQ, READ and WRITE. It drops in the cycle DONE is entered. address, we_L and re_L are decoded combinationally from state. data is driven only in WRITE, Z in every other state and during reset.
- The arbiter must not revoke bus_gnt while bus_req=1. Behaviour under grant revocation is undefined and is not verified.
- busy=1 in REQ, READ, WRITE and DONE.
- Arithmetic: pointers increment modulo 2^ADDR_W (16'hFFFF+1 wraps to 16'h0000). remaining is unsigned.
- Overlap: overlapping regions with dst>src copy forward word by word. No overlap correction is applied.
- Latency, with grant already high: start sampled at edge 0; REQ in cycle 1; READ k in cycle 2k; WRITE k in cycle 2k+1; DONE (done=1) in cycle 2N+2. With count==0, DONE is in cycle 1 and there is no bus activity.
- Each grant wait adds one cycle per cycle in which bus_gnt=0 while in REQ.

Test Plan:
- Reset values: reset_L=0 with random inputs -> bus_req=0, busy=0, done=0, we_L=NO_WR, re_L=NO_RD, data=Z; release reset -> outputs unchanged.
- Basic copy: mem[0100..0102]={1111,2222,3333}, src=0100, dst=0180, count=3, bus_gnt tied 1 -> mem[0180..0182]={1111,2222,3333}; done pulse in cycle 8; alternating MEM_RD/MEM_WR cycles observed.
- Zero count: count=0, start -> bus_req never asserts; done=1 in cycle 1; memory unchanged.
- Grant delay: bus_gnt asserted 5 cycles after bus_req rises, count=2 -> no MEM_RD before grant; data=Z while waiting; done 5 cycles later than the no-wait case.
- Wrap-around: src=FFFE, dst=0100, count=3 -> reads at FFFE, FFFF, 0000; writes to 0100, 0101, 0102.
- Protocol robustness: start pulse while busy -> ignored, transfer unchanged; reset_L=0 during the second WRITE of a 4-word copy -> immediate idle outputs, data=Z, only the first word copied, no done pulse.

Source files
------------

// File: rtl/dma_block_copy_pkg.sv
// Shared types for the block-copy DMA: memory bus condition codes and FSM states.
package dma_block_copy_pkg;

    // Memory strobes are active low, so the "do it" encodings are 0.
    typedef enum logic {
        MEM_WR = 1'b0,
        NO_WR  = 1'b1
    } wr_cond_code_t;

    typedef enum logic {
        MEM_RD = 1'b0,
        NO_RD  = 1'b1
    } rd_cond_code_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_block_copy_if.sv
// Control, arbitration and address/strobe signals of the block-copy DMA.
// The shared data bus is a tristate net and stays a plain inout port.
//
// Handshake: bus_req is held high from the request until the copy ends;
// the arbiter raises bus_gnt and keeps it high for as long as bus_req is
// high. The DMA only drives address/strobes meaningfully while granted.
interface dma_block_copy_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic                               start;
    logic [ADDR_W-1:0]                  src_addr;
    logic [ADDR_W-1:0]                  dst_addr;
    logic [CNT_W-1:0]                   count;
    logic                               bus_req;
    logic                               bus_gnt;
    logic [ADDR_W-1:0]                  address;
    dma_block_copy_pkg::wr_cond_code_t  we_L;
    dma_block_copy_pkg::rd_cond_code_t  re_L;
    logic                               busy;
    logic                               done;
    dma_block_copy_pkg::dma_state_t     state_dbg;

    // DMA side
    modport master (
        input  start, src_addr, dst_addr, count, bus_gnt,
        output bus_req, address, we_L, re_L, busy, done, state_dbg
    );

    // Host / arbiter / memory side
    modport slave (
        output start, src_addr, dst_addr, count, bus_gnt,
        input  bus_req, address, we_L, re_L, busy, done, state_dbg
    );
endinterface

// File: rtl/dma_block_copy.sv
// Block-copy DMA: a second bus master that copies count words from src to
// dst, one combinational-read cycle followed by one synchronous-write cycle
// per word. Pointers wrap modulo 2^ADDR_W; overlapping regions copy forward.
module dma_block_copy
    import dma_block_copy_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_L,
    dma_block_copy_if.master  bus,
    inout  wire  [DATA_W-1:0] data
);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    // State and datapath registers; reset aborts any copy in progress.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and datapath update; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_d   = bus.src_addr;
                    dst_d   = bus.dst_addr;
                    rem_d   = bus.count;
                    state_d = (bus.count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bus_gnt) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                buf_d   = data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                src_d   = src_q + ADDR_W'(1);
                dst_d   = dst_q + ADDR_W'(1);
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decoded purely from the current state.
    always_comb begin
        bus.bus_req   = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.address   = '0;
        bus.we_L      = NO_WR;
        bus.re_L      = NO_RD;
        bus.state_dbg = state_q;
        case (state_q)
            ST_REQ: begin
                bus.bus_req = 1'b1;
                bus.busy    = 1'b1;
            end
            ST_READ: begin
                bus.bus_req = 1'b1;
                bus.busy    = 1'b1;
                bus.address = src_q;
                bus.re_L    = MEM_RD;
            end
            ST_WRITE: begin
                bus.bus_req = 1'b1;
                bus.busy    = 1'b1;
                bus.address = dst_q;
                bus.we_L    = MEM_WR;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The data bus is only ours during a write cycle.
    assign data = (state_q == ST_WRITE) ? buf_q : {DATA_W{1'bz}};

endmodule
